multdiv_sequencer: RTL

//  Issues R-type mul/div from the DX stage to the multicycle multdiv unit and holds the pipeline until the result is ready.

---
 rtl/processor_pkg.sv | 19 +
 rtl/md_decode.sv | 25 ++
 rtl/multdiv_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/processor_pkg.sv
// Shared decode constants and the multdiv sequencer state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package processor_pkg;

  localparam logic [4:0]  OPC_RTYPE  = 5'b00000;
  localparam logic [4:0]  ALUOP_MUL  = 5'b00110;
  localparam logic [4:0]  ALUOP_DIV  = 5'b00111;
  localparam logic [31:0] STATUS_MUL = 32'd4;
  localparam logic [31:0] STATUS_DIV = 32'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } md_state_t;

endpackage

// File: rtl/md_decode.sv
// Recognises R-type mul/div in the X-stage instruction.
// Latency: combinational.
// Backpressure: none; pure decode.
module md_decode
  import processor_pkg::*;
(
  input  logic [31:0] instruction,
  output logic        is_md,
  output logic        is_div
);

  logic [4:0] opcode;
  logic [4:0] aluop;
  logic       unused_fields;

  assign opcode = instruction[31:27];
  assign aluop  = instruction[6:2];

  // Register fields are irrelevant here; rd==0 is still sequenced.
  assign unused_fields = ^{instruction[26:7], instruction[1:0]};

  assign is_div = (opcode == OPC_RTYPE) && (aluop == ALUOP_DIV);
  assign is_md  = (opcode == OPC_RTYPE) && ((aluop == ALUOP_MUL) || (aluop == ALUOP_DIV));

endmodule

// File: rtl/multdiv_sequencer.sv
// Issues DX mul/div to the multicycle multdiv unit and hands one result to XM.
// Latency: detect -> START pulse -> BUSY (>=1 cycle) -> DONE; 3 cycles minimum.
// Backpressure: stall holds PC/FD/DX until DONE; flush aborts. MD_WATCHDOG_EN bounds BUSY.
module multdiv_sequencer
  import processor_pkg::*;
#(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      DX_instruction,
  input  logic [31:0]      DX_opA,
  input  logic [31:0]      DX_opB,
  input  logic             flush,
  input  logic [31:0]      md_result,
  input  logic             md_resultRDY,
  input  logic             md_exception,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  output logic [31:0]      md_opA,
  output logic [31:0]      md_opB,
  output logic             stall,
  output logic             md_valid,
  output logic [31:0]      md_wdata,
  output logic             md_overflow,
  output logic [CNT_W-1:0] md_busy_cycles
);

  md_state_t        state;
  md_state_t        state_nxt;
  logic             is_md;
  logic             is_div;
  logic             op_div;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      wdata_q;
  logic             ovf_q;
  logic [31:0]      status;
  logic             detect;
  logic             rdy_hit;
  logic             wd_hit;

  md_decode u_decode (
    .instruction (DX_instruction),
    .is_md       (is_md),
    .is_div      (is_div)
  );

  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
  assign status  = op_div ? STATUS_DIV : STATUS_MUL;
  // Reset gating keeps stall low while reset is asserted even with a mul in DX.
  assign detect  = reset && (state == IDLE) && is_md && !flush;
  assign rdy_hit = (state == BUSY) && !flush && md_resultRDY;

`ifdef MD_WATCHDOG_EN
  assign wd_hit = (state == BUSY) && !flush && !md_resultRDY && (cnt_inc == CNT_W'(MAX_CYCLES));
`else
  localparam int unused_max_cycles = MAX_CYCLES;
  assign wd_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: flush wins everywhere past IDLE; DONE always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (detect) state_nxt = START;
      START:   state_nxt = flush ? IDLE : BUSY;
      BUSY: begin
        if (flush)                  state_nxt = IDLE;
        else if (rdy_hit || wd_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: stall and the start pulse drop in the same cycle as flush.
  always_comb begin
    ctrl_MULT   = 1'b0;
    ctrl_DIV    = 1'b0;
    stall       = 1'b0;
    md_valid    = 1'b0;
    md_wdata    = '0;
    md_overflow = 1'b0;
    case (state)
      IDLE:  stall = detect;
      START: begin
        stall     = !flush;
        ctrl_MULT = !flush && !op_div;
        ctrl_DIV  = !flush && op_div;
      end
      BUSY:  stall = !flush;
      DONE: begin
        md_valid    = !flush;
        md_wdata    = flush ? '0 : wdata_q;
        md_overflow = !flush && ovf_q;
      end
      default: ;
    endcase
  end

  // Operand latch, busy counter and result capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      md_opA         <= '0;
      md_opB         <= '0;
      op_div         <= 1'b0;
      cnt            <= '0;
      wdata_q        <= '0;
      ovf_q          <= 1'b0;
      md_busy_cycles <= '0;
    end else begin
      if (detect) begin
        md_opA <= DX_opA;
        md_opB <= DX_opB;
        op_div <= is_div;
      end
      if (state == START)     cnt <= '0;
      else if (state == BUSY) cnt <= cnt_inc;
      if (rdy_hit) begin
        wdata_q        <= md_exception ? status : md_result;
        ovf_q          <= md_exception;
        md_busy_cycles <= cnt_inc;
      end else if (wd_hit) begin
        wdata_q        <= status;
        ovf_q          <= 1'b1;
        md_busy_cycles <= cnt_inc;
      end
    end
  end

endmodule
